// File: rtl/xgmii_frame_gen.sv
// -----------------------------------------------------------------------------
// xgmii_frame_gen
//
// XGMII transmit-side frame generator. It takes payload words, starting at the
// destination MAC and including the FCS, from a 64-bit valid/ready stream. It
// emits them on a 64-bit XGMII bus in this order: a lane-0 /S/ preamble word,
// the lane-aligned data, and a /T/ terminate. It enforces a minimum number of
// idle characters between /T/ (or /E/) and the next /S/.
//
// Ports
//   clk            XGMII TX clock
//   rst            asynchronous active-high reset
//   in_valid       payload word valid
//   in_ready       payload word accepted when in_valid & in_ready (combinational)
//   in_data[63:0]  payload, byte 0 (first on wire) in bits 7:0
//   in_sof         first word of frame
//   in_eof         last word of frame
//   in_bytes[2:0]  valid bytes in the eof word (0 means 8)
//   xc_o[7:0]      XGMII control flags, bit k for lane k
//   xd_o[63:0]     XGMII data, lane k in bits 8k+7:8k
//   frame_done_o   one-cycle pulse coinciding with the /T/-carrying word
//   underrun_o     one-cycle pulse coinciding with the /E/ word
//   frame_cnt_o    frames completed with /T/ (wraps)
//   underrun_cnt_o frames aborted by underrun (wraps)
// -----------------------------------------------------------------------------
module xgmii_frame_gen #(
  parameter int MIN_IPG = 12,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [2:0]       in_bytes,
  output logic [7:0]       xc_o,
  output logic [63:0]      xd_o,
  output logic             frame_done_o,
  output logic             underrun_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] underrun_cnt_o
);

  localparam logic [7:0]  IDLE_C        = 8'h07;
  localparam logic [7:0]  TERM_C        = 8'hFD;
  localparam logic [7:0]  ERR_C         = 8'hFE;
  localparam logic [63:0] IDLE_WORD     = {8{IDLE_C}};
  localparam logic [63:0] ERR_WORD      = {8{ERR_C}};
  localparam logic [63:0] TERM_WORD     = {{7{IDLE_C}}, TERM_C};
  // /S/ in lane 0, six preamble bytes, SFD in lane 7.
  localparam logic [63:0] PREAMBLE_WORD = 64'hD5555555_555555FB;
  localparam logic [6:0]  MIN_IPG_C     = 7'(MIN_IPG);
  localparam logic [6:0]  IPG_MAX       = 7'd127;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_TERM,
    S_DROP
  } state_t;

  state_t      state;
  logic [6:0]  ipg_cnt;     // idle characters since the last /T/ or /E/
  logic [6:0]  ipg_plus8;
  logic        start;
  logic [7:0]  tail_lane;   // one-hot lane that carries /T/ in a partial eof word
  logic [7:0]  tail_keep;   // lanes below the /T/ lane that still carry data
  logic [7:0]  tail_xc;
  logic [63:0] tail_xd;

  // The sof word is held back in IDLE so that it is consumed as the first data
  // word once the preamble is out. Any other word seen in IDLE is discarded.
  always_comb begin
    // NOTE: assign every always_comb output a default before the case, so a
    // missed branch cannot infer a latch.
    in_ready = 1'b0;
    case (state)
      S_IDLE:         in_ready = in_valid & ~in_sof;
      S_DATA, S_DROP: in_ready = 1'b1;
      default:        in_ready = 1'b0;
    endcase
  end

  assign ipg_plus8 = (ipg_cnt > (IPG_MAX - 7'd8)) ? IPG_MAX : ipg_cnt + 7'd8;
  assign start     = (state == S_IDLE) & in_valid & in_sof & (ipg_cnt >= MIN_IPG_C);

  // Partial eof word with n = in_bytes (1..7): data in lanes < n, /T/ in lane n,
  // and idle in the remaining lanes. Every non-data lane is a control lane.
  always_comb begin
    tail_lane = 8'h01 << in_bytes;
    tail_keep = tail_lane - 8'h01;
    tail_xc   = ~tail_keep;
    tail_xd   = IDLE_WORD;
    for (int k = 0; k < 8; k++) begin
      if (tail_keep[k])      tail_xd[8*k +: 8] = in_data[8*k +: 8];
      else if (tail_lane[k]) tail_xd[8*k +: 8] = TERM_C;
      else                   tail_xd[8*k +: 8] = IDLE_C;
    end
  end

  // NOTE: all state below uses non-blocking assignments, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      ipg_cnt        <= IPG_MAX;  // first frame after reset may start at once
      xc_o           <= 8'hFF;
      xd_o           <= IDLE_WORD;
      frame_done_o   <= 1'b0;
      underrun_o     <= 1'b0;
      frame_cnt_o    <= '0;
      underrun_cnt_o <= '0;
    end else begin
      frame_done_o <= 1'b0;
      underrun_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            xc_o  <= 8'h01;
            xd_o  <= PREAMBLE_WORD;
            state <= S_DATA;
          end else begin
            xc_o    <= 8'hFF;
            xd_o    <= IDLE_WORD;
            ipg_cnt <= ipg_plus8;
          end
        end

        S_DATA: begin
          if (!in_valid) begin
            // The source starved mid-frame, so poison the frame with /E/.
            xc_o           <= 8'hFF;
            xd_o           <= ERR_WORD;
            underrun_o     <= 1'b1;
            underrun_cnt_o <= underrun_cnt_o + 1'b1;
            ipg_cnt        <= '0;
            state          <= S_DROP;
          end else if (in_eof && (in_bytes != 3'd0)) begin
            xc_o         <= tail_xc;
            xd_o         <= tail_xd;
            frame_done_o <= 1'b1;
            frame_cnt_o  <= frame_cnt_o + 1'b1;
            // Lanes above the /T/ lane are idle and count toward the gap.
            ipg_cnt      <= 7'd7 - {4'd0, in_bytes};
            state        <= S_IDLE;
          end else begin
            xc_o <= 8'h00;
            xd_o <= in_data;
            if (in_eof) state <= S_TERM;
          end
        end

        S_TERM: begin
          xc_o         <= 8'hFF;
          xd_o         <= TERM_WORD;
          frame_done_o <= 1'b1;
          frame_cnt_o  <= frame_cnt_o + 1'b1;
          ipg_cnt      <= 7'd7;
          state        <= S_IDLE;
        end

        S_DROP: begin
          xc_o    <= 8'hFF;
          xd_o    <= IDLE_WORD;
          ipg_cnt <= ipg_plus8;
          if (in_valid && in_eof) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_xgmii_frame_gen
//
// Frame-level reference model: each frame is described by its length, eof
// byte count, leading stray words and optional underrun point. The model
// expands that description into the expected XGMII word sequence from the
// wire rules (gap arithmetic, /T/ lane placement, /E/ abort), and the bench
// compares that sequence word by word against the DUT output.
// -----------------------------------------------------------------------------
module tb_xgmii_frame_gen;

  localparam int MIN_IPG = 12;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             in_sof;
  logic             in_eof;
  logic [2:0]       in_bytes;
  logic [7:0]       xc_o;
  logic [63:0]      xd_o;
  logic             frame_done_o;
  logic             underrun_o;
  logic [CNT_W-1:0] frame_cnt_o;
  logic [CNT_W-1:0] underrun_cnt_o;

  always #5 clk = ~clk;

  xgmii_frame_gen #(.MIN_IPG(MIN_IPG), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_sof         (in_sof),
    .in_eof         (in_eof),
    .in_bytes       (in_bytes),
    .xc_o           (xc_o),
    .xd_o           (xd_o),
    .frame_done_o   (frame_done_o),
    .underrun_o     (underrun_o),
    .frame_cnt_o    (frame_cnt_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  typedef struct {
    logic [63:0] d;
    logic        sof;
    logic        eof;
    logic [2:0]  nb;
    logic        gap;   // drop in_valid for one cycle before this word
  } in_t;

  typedef struct {
    logic [7:0]       xc;
    logic [63:0]      xd;
    logic             done;
    logic             und;
    logic [CNT_W-1:0] fc;
    logic [CNT_W-1:0] uc;
  } exp_t;

  in_t  in_q[$];
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Model state between frames.
  int               carry;    // idle characters already on the wire since /T/ or /E/
  int               pending;  // idle words owed to the words dropped after an underrun
  logic [CNT_W-1:0] fc_m;
  logic [CNT_W-1:0] uc_m;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic push_exp(input logic [7:0] xc, input logic [63:0] xd,
                          input logic done, input logic und);
    exp_t e;
    if (done) fc_m = fc_m + 1;
    if (und)  uc_m = uc_m + 1;
    e.xc = xc; e.xd = xd; e.done = done; e.und = und; e.fc = fc_m; e.uc = uc_m;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_exp(8'hFF, {8{8'h07}}, 1'b0, 1'b0);
  endtask

  // nw data words, eof byte count nb, strays non-sof words ahead of the frame,
  // und_at > 0 starves the source after that many data words.
  task automatic add_frame(input int nw, input int nb, input int strays, input int und_at);
    logic [63:0] words[$];
    logic [63:0] w;
    logic [7:0]  xc;
    in_t         iw;
    int          need;
    int          n_idle;
    for (int s = 0; s < strays; s++) begin
      iw.d = rnd64(); iw.sof = 1'b0; iw.eof = 1'b0; iw.nb = 3'($urandom); iw.gap = 1'b0;
      in_q.push_back(iw);
    end
    // Every idle word adds 8 idle characters; the frame may not start before
    // the gap reaches MIN_IPG, and each stray or dropped word costs one idle word.
    need   = (carry >= MIN_IPG) ? 0 : (MIN_IPG - carry + 7) / 8;
    n_idle = pending + strays;
    if (need > n_idle) n_idle = need;
    push_idle(n_idle);
    pending = 0;
    push_exp(8'h01, 64'hD5555555555555FB, 1'b0, 1'b0);
    for (int i = 0; i < nw; i++) begin
      w = rnd64();
      words.push_back(w);
      iw.d = w; iw.sof = (i == 0); iw.eof = (i == nw - 1); iw.nb = 3'(nb);
      iw.gap = (und_at > 0) && (i == und_at);
      in_q.push_back(iw);
    end
    if (und_at > 0) begin
      for (int i = 0; i < und_at; i++) push_exp(8'h00, words[i], 1'b0, 1'b0);
      push_exp(8'hFF, {8{8'hFE}}, 1'b0, 1'b1);
      carry   = 0;
      pending = nw - und_at;
    end else begin
      for (int i = 0; i < nw - 1; i++) push_exp(8'h00, words[i], 1'b0, 1'b0);
      if (nb == 0) begin
        push_exp(8'h00, words[nw-1], 1'b0, 1'b0);
        push_exp(8'hFF, 64'h07070707070707FD, 1'b1, 1'b0);
        carry = 7;
      end else begin
        w = words[nw-1];
        for (int k = 0; k < 8; k++) begin
          if (k < nb) begin
            xc[k] = 1'b0;
          end else begin
            xc[k] = 1'b1;
            w[8*k +: 8] = (k == nb) ? 8'hFD : 8'h07;
          end
        end
        push_exp(xc, w, 1'b1, 1'b0);
        carry = 7 - nb;
      end
    end
  endtask

  task automatic flush_pending();
    push_idle(pending);
    pending = 0;
  endtask

  task automatic drive_all(input string name);
    in_t  w;
    logic acc;
    int   tries;
    while (in_q.size() > 0) begin
      w = in_q.pop_front();
      if (w.gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = w.d; in_sof = w.sof; in_eof = w.eof; in_bytes = w.nb;
      acc   = 1'b0;
      tries = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        tries++;
        if (!acc && tries > 64) begin
          errors++; checks++;
          $display("FAIL %s stall: in_ready=%b for 64 cycles, required 1", name, in_ready);
          in_q.delete();
          break;
        end
      end
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic check_all(input string name, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (xc_o !== e.xc || xd_o !== e.xd || frame_done_o !== e.done ||
          underrun_o !== e.und || frame_cnt_o !== e.fc || underrun_cnt_o !== e.uc) begin
        errors++;
        $display("FAIL %s word %0d: got xc=%h xd=%h done=%b und=%b fc=%0d uc=%0d, required xc=%h xd=%h done=%b und=%b fc=%0d uc=%0d",
                 name, i, xc_o, xd_o, frame_done_o, underrun_o, frame_cnt_o, underrun_cnt_o,
                 e.xc, e.xd, e.done, e.und, e.fc, e.uc);
      end
    end
  endtask

  // Call at posedge+1 (or any time before the next edge).
  task automatic run_scenario(input string name);
    int n;
    flush_pending();
    n = exp_q.size();
    fork
      drive_all(name);
      check_all(name, n);
    join
  endtask

  // Idle long enough for the gap counter to saturate.
  task automatic idle_wait();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    carry   = 127;
    pending = 0;
  endtask

  task automatic check_idle_state(input string name);
    checks++;
    if (xc_o !== 8'hFF || xd_o !== {8{8'h07}}) begin
      errors++;
      $display("FAIL %s idle word: got xc=%h xd=%h, required xc=ff xd=0707070707070707", name, xc_o, xd_o);
    end
    checks++;
    if (frame_done_o !== 1'b0 || underrun_o !== 1'b0) begin
      errors++;
      $display("FAIL %s pulses: got done=%b und=%b, required 0 0", name, frame_done_o, underrun_o);
    end
    checks++;
    if (frame_cnt_o !== '0 || underrun_cnt_o !== '0) begin
      errors++;
      $display("FAIL %s counters: got fc=%0d uc=%0d, required 0 0", name, frame_cnt_o, underrun_cnt_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = '0; in_bytes = '0;
    fc_m = '0; uc_m = '0; carry = 127; pending = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_state("reset_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_state("reset_release");
  endtask

  task automatic test_single_64();
    idle_wait();
    add_frame(8, 0, 0, 0);
    run_scenario("single_64");
  endtask

  task automatic test_back_to_back_b4();
    idle_wait();
    add_frame(8, 4, 0, 0);
    add_frame(5, 0, 0, 0);
    run_scenario("b2b_eof4");
  endtask

  task automatic test_back_to_back_b0();
    idle_wait();
    add_frame(6, 0, 0, 0);
    add_frame(3, 7, 0, 0);
    add_frame(2, 0, 0, 0);
    run_scenario("b2b_eof0");
  endtask

  task automatic test_underrun();
    idle_wait();
    add_frame(10, 0, 0, 3);
    add_frame(4, 2, 0, 0);
    run_scenario("underrun");
  endtask

  task automatic test_stray();
    idle_wait();
    add_frame(1, 1, 3, 0);
    add_frame(2, 6, 2, 0);
    run_scenario("stray_single");
  endtask

  task automatic test_random();
    int nw, nb, st, und;
    idle_wait();
    for (int f = 0; f < 12; f++) begin
      nw  = $urandom_range(1, 9);
      nb  = $urandom_range(0, 7);
      st  = $urandom_range(0, 2);
      und = 0;
      if (nw >= 2 && $urandom_range(0, 4) == 0) und = $urandom_range(1, nw - 1);
      add_frame(nw, nb, st, und);
    end
    run_scenario("random");
  endtask

  task automatic test_reset_mid_frame();
    idle_wait();
    in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b0; in_bytes = 3'd0; in_data = rnd64();
    @(posedge clk); #1;   // preamble edge
    @(posedge clk); #1;   // first data word accepted
    in_sof = 1'b0; in_data = rnd64();
    checks++;
    if (xc_o !== 8'h00) begin
      errors++;
      $display("FAIL mid_frame_data: got xc=%h, required 00", xc_o);
    end
    #2 rst = 1'b1;
    #1;
    check_idle_state("reset_async");
    in_valid = 1'b0;
    rst = 1'b0;
    fc_m = '0; uc_m = '0; carry = 127; pending = 0;
    #2;
    add_frame(3, 5, 0, 0);
    run_scenario("after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_64();
    test_back_to_back_b4();
    test_back_to_back_b0();
    test_underrun();
    test_stray();
    test_random();
    test_reset_mid_frame();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xgmii_frame_gen.md
Name: xgmii_frame_gen

Overview:
XGMII transmit-side frame generator for the 10G PTP test environment. It takes payload words from a 64-bit valid/ready stream, starting at the destination MAC and including the FCS. It drives a 64-bit XGMII bus: lane-0 /S/ plus preamble/SFD, aligned data, /T/, and an enforced minimum inter-packet gap. It sources frames into the DUT RX path, or models the link partner for the XGMII frame monitor.

Parameters:
MIN_IPG, 12, minimum idle characters between /T/ and next /S/ (legal 5..100)
CNT_W, 32, width of frame/underrun statistic counters

Ports:
clk  in  1  XGMII TX clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  payload word valid
in_ready  out  1  payload word accepted when in_valid&in_ready
in_data  in  64  payload; byte 0 (first on wire) in bits 7:0, lane k in bits 8k+7:8k
in_sof  in  1  first word of frame
in_eof  in  1  last word of frame
in_bytes  in  3  valid bytes in eof word, lanes 0..n-1; 0 means 8; ignored without eof
xc_o  out  8  XGMII control flags, bit k for lane k
xd_o  out  64  XGMII data
frame_done_o  out  1  one-cycle pulse with the /T/-carrying word
underrun_o  out  1  one-cycle pulse with the /E/ word
frame_cnt_o  out  CNT_W  frames completed with /T/
underrun_cnt_o  out  CNT_W  aborted frames

Behaviour:
- All outputs are registered, except in_ready, which is combinational from state and in_sof. An accepted word appears on xd_o on the next cycle.
- Reset (async): state IDLE; xc_o=8'hFF; xd_o=all lanes 8'h07; pulses 0; counters 0; ipg_cnt saturated at 127, so the first frame may start at once. Reset mid-frame truncates the wire frame without /T/. This is accepted.
- ipg_cnt: 7-bit saturating count of idle characters emitted since the last /T/ or /E/.
  - A /T/ word in lane n loads ipg_cnt=7-n.
  - An /E/ word loads 0.
  - Each all-idle word adds 8.
- States:
  - IDLE: drive the idle word, unless a start is taken.
    - in_ready = in_valid & ~in_sof. Stray non-sof words are accepted and discarded.
    - Start condition: in_valid & in_sof & ipg_cnt>=MIN_IPG. On start, register the preamble word xc=8'h01, xd={D5,55,55,55,55,55,55,FB} (lane0=FB), then go to DATA. The sof word is not consumed in IDLE.
  - DATA: in_ready=1.
    - valid & ~eof: xc=0, xd=in_data.
    - valid & eof & bytes n in 1..7: lanes <n carry data (xc=0); lane n is FD (xc=1); lanes >n are 07 (xc=1). Pulse frame_done_o, increment frame_cnt_o, go to IDLE.
    - valid & eof & bytes=0: full data word, go to TERM.
    - ~in_valid: underrun. Register xc=8'hFF, xd=all FE, pulse underrun_o, increment underrun_cnt_o, go to DROP.
    - in_sof while in DATA is ignored; the word is treated as data.
  - TERM: register xc=8'hFF, xd={07 x7, FD}. Pulse frame_done_o, increment frame_cnt_o, go to IDLE. in_ready=0.
  - DROP: drive idle words. in_ready=1; discard words until an eof word is accepted, then go to IDLE.
- /S/ appears only in lane 0. Because the preamble fills one word, the payload needs no realignment.
- Counters wrap at 2^CNT_W.

Test Plan:
- Reset then a 64-byte frame (8 words, eof bytes=0):
  - Cycle after start: preamble word.
  - Then 8 data words, then TERM word xc=FF, xd lane0=FD.
  - frame_done_o 1 cycle, frame_cnt_o=1.
- Two back-to-back frames, first eof bytes=4, MIN_IPG=12:
  - /T/ in lane 4, xc=F0.
  - Exactly two idle words (3+8+8=19≥12) before the second preamble.
  - in_valid held high throughout.
- Back-to-back frames, first eof bytes=0: TERM word, one idle word (7+8=15), then preamble. Check that no idle word is dropped or added.
- Deassert in_valid after word 3 of a 10-word frame:
  - Next output xc=FF, xd=FEFE..FE; underrun_o pulse, underrun_cnt_o=1.
  - Remaining words consumed with idle output; next frame starts normally.
- Stray non-sof words in IDLE are consumed (in_ready=1) with idle output. A single-word frame (sof&eof, bytes=1) produces preamble, then xc=FE with lane1=FD.
- Assert rst during DATA: xc_o/xd_o become idle asynchronously; counters clear; the next sof frame starts without an IPG wait.
